// File: rtl/sparkle_pkg.sv
// Shared types and helpers for the sparkle light-show sequencer.
// Holds the FSM state encoding, LFSR constants and the dropped-light index function.
package sparkle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TBL_STEP,
    RND_ON,
    RND_OFF
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps at bits 15, 13, 12 and 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [4:0] drop_index(input logic [15:0] l, input logic [15:0] n);
    return 5'(l % n);
  endfunction

endpackage

// File: rtl/ms_timebase.sv
// Millisecond timebase: a prescaler feeding a ms counter, both cleared on step entry.
// done is high on the final clock of a step lasting max(target,1) milliseconds.
module ms_timebase #(
  parameter int CLKS_PER_MS = 5000,
  parameter int MS_W        = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [MS_W-1:0] target,
  output logic            done
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  logic [PW-1:0]   presc_reg;
  logic [MS_W-1:0] ms_reg;
  logic            tick;
  logic [MS_W-1:0] last_ms;

  assign tick    = (presc_reg == PW'(CLKS_PER_MS - 1));
  // A zero duration behaves as one millisecond
  assign last_ms = (target == '0) ? '0 : target - MS_W'(1);
  assign done    = tick && (ms_reg == last_ms);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      ms_reg    <= '0;
    end else if (clear) begin
      presc_reg <= '0;
      ms_reg    <= '0;
    end else if (tick) begin
      presc_reg <= '0;
      ms_reg    <= ms_reg + MS_W'(1);
    end else begin
      presc_reg <= presc_reg + PW'(1);
    end
  end

endmodule

// File: rtl/sparkle_seq.sv
// Light-show sequencer: plays a loadable step table or a random sparkle pattern
// for a programmable number of passes, then pulses finished.
module sparkle_seq
  import sparkle_pkg::*;
#(
  parameter int NUM_LIGHTS  = 8,
  parameter int NUM_STEPS   = 16,
  parameter int CLKS_PER_MS = 5000,
  parameter int MS_W        = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         go,
  input  logic                         abort,
  input  logic                         mode,
  input  logic [7:0]                   repeats,
  input  logic [$clog2(NUM_STEPS)-1:0] last_step,
  input  logic [MS_W-1:0]              rand_on_ms,
  input  logic [MS_W-1:0]              rand_off_ms,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic [NUM_LIGHTS-1:0]        wr_mask,
  input  logic [MS_W-1:0]              wr_dur,
  output logic [NUM_LIGHTS-1:0]        lights,
  output logic                         busy,
  output logic                         finished,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx
);

  localparam int AW = $clog2(NUM_STEPS);

  logic [NUM_LIGHTS-1:0] tbl_mask [NUM_STEPS];
  logic [MS_W-1:0]       tbl_dur  [NUM_STEPS];

  state_t                state_reg,    state_next;
  logic [NUM_LIGHTS-1:0] lights_reg,   lights_next;
  logic [AW-1:0]         step_reg,     step_next;
  logic [MS_W-1:0]       dur_reg,      dur_next;
  logic [7:0]            pass_reg,     pass_next;
  logic [15:0]           lfsr_reg,     lfsr_next;
  logic                  finished_reg, finished_next;
  logic                  mode_reg,     mode_next;
  logic [7:0]            rep_reg,      rep_next;
  logic [AW-1:0]         last_reg,     last_next;
  logic [MS_W-1:0]       on_reg,       on_next;
  logic [MS_W-1:0]       off_reg,      off_next;

  logic                  tb_clear;
  logic                  tb_done;
  logic [MS_W-1:0]       tb_target;
  logic [15:0]           lfsr_adv;
  logic [4:0]            drop;
  logic [NUM_LIGHTS-1:0] drop_mask;
  logic                  pass_end;
  logic [7:0]            pass_inc;

  // Table is written only while idle, so playback always sees a stable table
  always_ff @(posedge clk) begin
    if (wr_en && state_reg == IDLE) begin
      tbl_mask[wr_addr] <= wr_mask;
      tbl_dur[wr_addr]  <= wr_dur;
    end
  end

  always_comb begin
    tb_target = '0;
    case (state_reg)
      TBL_STEP: tb_target = dur_reg;
      RND_ON:   tb_target = on_reg;
      RND_OFF:  tb_target = off_reg;
      default:  tb_target = '0;
    endcase
  end

  ms_timebase #(
    .CLKS_PER_MS(CLKS_PER_MS),
    .MS_W       (MS_W)
  ) u_timebase (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tb_clear),
    .target(tb_target),
    .done  (tb_done)
  );

  // The dropped light uses the already-advanced LFSR value
  assign lfsr_adv = lfsr_advance(lfsr_reg);
  assign drop     = drop_index(lfsr_adv, 16'(NUM_LIGHTS));
  assign pass_inc = pass_reg + 8'd1;

  always_comb begin
    drop_mask = '1;
    for (int i = 0; i < NUM_LIGHTS; i++) drop_mask[i] = (5'(i) != drop);
  end

  always_comb begin
    state_next    = state_reg;
    lights_next   = lights_reg;
    step_next     = step_reg;
    dur_next      = dur_reg;
    pass_next     = pass_reg;
    lfsr_next     = lfsr_reg;
    finished_next = 1'b0;
    mode_next     = mode_reg;
    rep_next      = rep_reg;
    last_next     = last_reg;
    on_next       = on_reg;
    off_next      = off_reg;
    tb_clear      = 1'b0;
    pass_end      = 1'b0;

    case (state_reg)
      IDLE: begin
        tb_clear = 1'b1;
        if (go) begin
          mode_next = mode;
          rep_next  = repeats;
          last_next = last_step;
          on_next   = rand_on_ms;
          off_next  = rand_off_ms;
          pass_next = '0;
          step_next = '0;
          if (mode) begin
            state_next  = RND_ON;
            lights_next = '1;
          end else begin
            state_next  = TBL_STEP;
            lights_next = tbl_mask[0];
            dur_next    = tbl_dur[0];
          end
        end
      end
      TBL_STEP: begin
        if (tb_done) begin
          tb_clear = 1'b1;
          if (step_reg != last_reg) begin
            step_next   = step_reg + AW'(1);
            lights_next = tbl_mask[step_reg + AW'(1)];
            dur_next    = tbl_dur[step_reg + AW'(1)];
          end else begin
            pass_end = 1'b1;
          end
        end
      end
      RND_ON: begin
        if (tb_done) begin
          tb_clear    = 1'b1;
          lfsr_next   = lfsr_adv;
          lights_next = drop_mask;
          state_next  = RND_OFF;
        end
      end
      RND_OFF: begin
        if (tb_done) begin
          tb_clear = 1'b1;
          pass_end = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // repeats == 0 never matches a post-increment count of at least 1 before wrap
    if (pass_end) begin
      if (rep_reg != 8'd0 && pass_inc == rep_reg) begin
        state_next    = IDLE;
        lights_next   = '0;
        step_next     = '0;
        pass_next     = '0;
        finished_next = 1'b1;
      end else begin
        pass_next = pass_inc;
        step_next = '0;
        if (mode_reg) begin
          state_next  = RND_ON;
          lights_next = '1;
        end else begin
          state_next  = TBL_STEP;
          lights_next = tbl_mask[0];
          dur_next    = tbl_dur[0];
        end
      end
    end

    if (abort) begin
      state_next    = IDLE;
      lights_next   = '0;
      step_next     = '0;
      pass_next     = '0;
      finished_next = 1'b0;
      tb_clear      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lights_reg   <= '0;
      step_reg     <= '0;
      dur_reg      <= '0;
      pass_reg     <= '0;
      lfsr_reg     <= LFSR_SEED;
      finished_reg <= 1'b0;
      mode_reg     <= 1'b0;
      rep_reg      <= '0;
      last_reg     <= '0;
      on_reg       <= '0;
      off_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      lights_reg   <= lights_next;
      step_reg     <= step_next;
      dur_reg      <= dur_next;
      pass_reg     <= pass_next;
      lfsr_reg     <= lfsr_next;
      finished_reg <= finished_next;
      mode_reg     <= mode_next;
      rep_reg      <= rep_next;
      last_reg     <= last_next;
      on_reg       <= on_next;
      off_reg      <= off_next;
    end
  end

  assign lights   = lights_reg;
  assign busy     = (state_reg != IDLE);
  assign finished = finished_reg;
  assign step_idx = step_reg;

endmodule

// File: tb/tb_sparkle_seq.sv
// Self-checking bench for sparkle_seq: expected per-cycle outputs are queued
// up front and compared cycle by cycle on the falling clock edge.
module tb_sparkle_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  repeats = '0;
  logic [3:0]  last_step = '0;
  logic [19:0] rand_on_ms = '0;
  logic [19:0] rand_off_ms = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_mask = '0;
  logic [19:0] wr_dur = '0;
  logic [7:0]  lights;
  logic        busy;
  logic        finished;
  logic [3:0]  step_idx;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] lights;
    logic       fin;
    logic       busy;
    logic [3:0] step;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_lfsr = 16'hACE1;

  always #5 clk = ~clk;

  sparkle_seq #(
    .NUM_LIGHTS (8),
    .NUM_STEPS  (16),
    .CLKS_PER_MS(4),
    .MS_W       (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .abort      (abort),
    .mode       (mode),
    .repeats    (repeats),
    .last_step  (last_step),
    .rand_on_ms (rand_on_ms),
    .rand_off_ms(rand_off_ms),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_mask    (wr_mask),
    .wr_dur     (wr_dur),
    .lights     (lights),
    .busy       (busy),
    .finished   (finished),
    .step_idx   (step_idx)
  );

  task automatic push(input logic [7:0] l, input logic f, input logic b,
                      input logic [3:0] s, input int n);
    exp_t e;
    e.lights = l; e.fin = f; e.busy = b; e.step = s;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic push_table_pass();
    push(8'hFF, 1'b0, 1'b1, 4'd0, 8);
    push(8'hFE, 1'b0, 1'b1, 4'd1, 4);
    push(8'hF0, 1'b0, 1'b1, 4'd2, 12);
  endtask

  task automatic push_finish();
    push(8'h00, 1'b1, 1'b0, 4'd0, 1);
    push(8'h00, 1'b0, 1'b0, 4'd0, 1);
  endtask

  task automatic push_idle(input int n);
    push(8'h00, 1'b0, 1'b0, 4'd0, n);
  endtask

  // Pops one expected entry per cycle; optional injections of wr_en/go/abort
  // are driven after the comparison at the given cycle index (-1 = none).
  task automatic check_seq(input string name, input int wr_at, input int go_at, input int abort_at);
    exp_t e;
    int   i = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors += 4;
      if (lights !== e.lights) begin
        miscompares++;
        $display("FAIL %s lights cycle %0d: got %h want %h", name, i, lights, e.lights);
      end
      if (finished !== e.fin) begin
        miscompares++;
        $display("FAIL %s finished cycle %0d: got %b want %b", name, i, finished, e.fin);
      end
      if (busy !== e.busy) begin
        miscompares++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, i, busy, e.busy);
      end
      if (step_idx !== e.step) begin
        miscompares++;
        $display("FAIL %s step_idx cycle %0d: got %0d want %0d", name, i, step_idx, e.step);
      end
      wr_en = (i == wr_at);
      go    = (i == go_at);
      abort = (i == abort_at);
      @(negedge clk);
      i++;
    end
    wr_en = 1'b0;
    go    = 1'b0;
    abort = 1'b0;
    $display("%s: %0d cycles checked", name, i);
  endtask

  task automatic write_step(input logic [3:0] a, input logic [7:0] m, input logic [19:0] d);
    wr_addr = a; wr_mask = m; wr_dur = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start(input logic m, input logic [7:0] r, input logic [3:0] ls);
    mode = m; repeats = r; last_step = ls; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic load_table();
    write_step(4'd0, 8'hFF, 20'd2);
    write_step(4'd1, 8'hFE, 20'd1);
    write_step(4'd2, 8'hF0, 20'd3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (lights !== 8'h00) begin miscompares++; $display("FAIL reset lights: got %h want 00", lights); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", busy); end
    if (finished !== 1'b0) begin miscompares++; $display("FAIL reset finished: got %b want 0", finished); end
    if (step_idx !== 4'd0) begin miscompares++; $display("FAIL reset step_idx: got %0d want 0", step_idx); end
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    @(negedge clk);
  endtask

  task automatic test_table_once();
    push_table_pass();
    push_finish();
    start(1'b0, 8'd1, 4'd2);
    check_seq("table_once", -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    push_table_pass();
    push_table_pass();
    push_finish();
    start(1'b0, 8'd2, 4'd2);
    check_seq("back_to_back", -1, -1, -1);
  endtask

  task automatic test_random();
    logic [7:0] one = 8'h01;
    rand_on_ms = 20'd2;
    rand_off_ms = 20'd1;
    for (int p = 0; p < 4; p++) begin
      push(8'hFF, 1'b0, 1'b1, 4'd0, 8);
      m_lfsr = model_next(m_lfsr);
      push(8'hFF ^ (one << m_lfsr[2:0]), 1'b0, 1'b1, 4'd0, 4);
    end
    push_finish();
    start(1'b1, 8'd4, 4'd0);
    check_seq("random", -1, -1, -1);
  endtask

  task automatic test_abort();
    push(8'hFF, 1'b0, 1'b1, 4'd0, 5);
    push_idle(3);
    start(1'b0, 8'd1, 4'd2);
    check_seq("abort_table", -1, -1, 4);
    push_table_pass();
    push_finish();
    start(1'b0, 8'd1, 4'd2);
    check_seq("restart_after_abort", -1, -1, -1);
    // Abort inside RND_ON, so the LFSR has not advanced
    push(8'hFF, 1'b0, 1'b1, 4'd0, 3);
    push_idle(3);
    start(1'b1, 8'd4, 4'd0);
    check_seq("abort_random", -1, -1, 2);
  endtask

  task automatic test_busy_ignore();
    wr_addr = 4'd1; wr_mask = 8'h00; wr_dur = 20'd5;
    push_table_pass();
    push_finish();
    start(1'b0, 8'd1, 4'd2);
    check_seq("busy_ignore", 3, 10, -1);
    push_table_pass();
    push_finish();
    start(1'b0, 8'd1, 4'd2);
    check_seq("table_unchanged", -1, -1, -1);
  endtask

  task automatic test_dur_zero();
    write_step(4'd0, 8'h0F, 20'd0);
    push(8'h0F, 1'b0, 1'b1, 4'd0, 40);
    push_idle(2);
    start(1'b0, 8'd0, 4'd0);
    check_seq("dur_zero_forever", -1, -1, 39);
  endtask

  task automatic test_async_reset();
    load_table();
    start(1'b0, 8'd1, 4'd2);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (lights !== 8'h00) begin miscompares++; $display("FAIL async_reset lights: got %h want 00", lights); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL async_reset busy: got %b want 0", busy); end
    if (finished !== 1'b0) begin miscompares++; $display("FAIL async_reset finished: got %b want 0", finished); end
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr = 16'hACE1;
    push_idle(3);
    @(negedge clk);
    check_seq("after_async_reset", -1, -1, -1);
  endtask

  initial begin
    test_reset();
    load_table();
    test_table_once();
    test_back_to_back();
    test_random();
    test_abort();
    test_busy_ignore();
    test_dur_zero();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
